// File: rtl/control.sv
// Main control unit of the single-issue RV32I datapath: decodes the 7-bit opcode
// into registered datapath control strobes with one cycle of latency.
module control (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    output logic       reg_write_o,
    output logic [1:0] alu_op_o,
    output logic       alu_src_o,
    output logic       mem_write_o,
    output logic       mem_read_o,
    output logic       men_to_reg_o,
    output logic       branch_o
);

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALU operation classes understood by the ALU-control block
    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_R_TYPE = 2'b10,
        ALU_I_TYPE = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    alu_src;
        logic    men_to_reg;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        reg_write: 1'b0, alu_src: 1'b0, men_to_reg: 1'b0, mem_read: 1'b0,
        mem_write: 1'b0, branch: 1'b0, alu_op: ALU_ADD
    };

    ctrl_t ctrl_next;
    ctrl_t ctrl_q;

    // Full 7-bit match: anything not listed, including [1:0] != 2'b11, is a NOP.
    always_comb begin
        // NOTE: default the whole row first so every path assigns every field and no latch is inferred.
        ctrl_next = CTRL_NOP;
        unique case (opcode_i)
            OP_R_TYPE: begin
                ctrl_next.reg_write = 1'b1;
                ctrl_next.alu_op    = ALU_R_TYPE;
            end
            OP_I_ALU: begin
                ctrl_next.reg_write = 1'b1;
                ctrl_next.alu_src   = 1'b1;
                ctrl_next.alu_op    = ALU_I_TYPE;
            end
            OP_LOAD: begin
                ctrl_next.reg_write  = 1'b1;
                ctrl_next.alu_src    = 1'b1;
                ctrl_next.men_to_reg = 1'b1;
                ctrl_next.mem_read   = 1'b1;
            end
            OP_STORE: begin
                ctrl_next.alu_src   = 1'b1;
                ctrl_next.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_next.branch = 1'b1;
                ctrl_next.alu_op = ALU_BRANCH;
            end
            default: ctrl_next = CTRL_NOP;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignment keeps the register update order-independent across always_ff blocks.
        if (rst_i) begin
            ctrl_q <= CTRL_NOP;
        end else begin
            ctrl_q <= ctrl_next;
        end
    end

    assign reg_write_o  = ctrl_q.reg_write;
    assign alu_src_o    = ctrl_q.alu_src;
    assign men_to_reg_o = ctrl_q.men_to_reg;
    assign mem_read_o   = ctrl_q.mem_read;
    assign mem_write_o  = ctrl_q.mem_write;
    assign branch_o     = ctrl_q.branch;
    assign alu_op_o     = ctrl_q.alu_op;

endmodule

// File: tb/tb_control.sv
// Self-checking bench for control: directed scenarios plus random opcode/reset
// traffic compared against a table-driven reference of the decode rules.
module tb_control;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [6:0] opcode_i;
    logic       reg_write_o;
    logic [1:0] alu_op_o;
    logic       alu_src_o;
    logic       mem_write_o;
    logic       mem_read_o;
    logic       men_to_reg_o;
    logic       branch_o;

    int checks_total  = 0;
    int checks_passed = 0;

    // Row layout: {reg_write, alu_src, men_to_reg, mem_read, mem_write, branch, alu_op[1:0]}
    logic [7:0] ref_row [128];

    control dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .opcode_i     (opcode_i),
        .reg_write_o  (reg_write_o),
        .alu_op_o     (alu_op_o),
        .alu_src_o    (alu_src_o),
        .mem_write_o  (mem_write_o),
        .mem_read_o   (mem_read_o),
        .men_to_reg_o (men_to_reg_o),
        .branch_o     (branch_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [7:0] dut_row();
        return {reg_write_o, alu_src_o, men_to_reg_o, mem_read_o, mem_write_o, branch_o, alu_op_o};
    endfunction

    // Apply one cycle of stimulus, then compare the registered row against the reference.
    task automatic step(input string tag, input logic rst, input logic [6:0] op);
        logic [7:0] expected;
        logic [7:0] row;
        rst_i    = rst;
        opcode_i = op;
        @(posedge clk_i);
        #1;
        expected = rst ? 8'h00 : ref_row[op];
        row      = dut_row();
        check(tag, row, expected);
        check({tag, "_rd_wr_excl"}, {7'd0, row[4] & row[3]}, 8'd0);
        check({tag, "_wr_excl"}, {7'd0, row[7] & (row[3] | row[2])}, 8'd0);
    endtask

    initial begin
        int nonzero;
        logic [6:0] legal [5];

        for (int i = 0; i < 128; i++) ref_row[i] = 8'b0000_0000;
        ref_row[7'b0110011] = 8'b1_0_0_0_0_0_10;
        ref_row[7'b0010011] = 8'b1_1_0_0_0_0_11;
        ref_row[7'b0000011] = 8'b1_1_1_1_0_0_00;
        ref_row[7'b0100011] = 8'b0_1_0_0_1_0_00;
        ref_row[7'b1100011] = 8'b0_0_0_0_0_1_01;
        legal = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};

        rst_i    = 1'b1;
        opcode_i = 7'b0110011;
        @(negedge clk_i);

        // Reset held two cycles with R-type present, then release.
        step("reset0", 1'b1, 7'b0110011);
        step("reset1", 1'b1, 7'b0110011);
        step("release_r", 1'b0, 7'b0110011);

        // Each recognised opcode held for two cycles.
        for (int i = 0; i < 5; i++) begin
            step("seq_a", 1'b0, legal[i]);
            step("seq_b", 1'b0, legal[i]);
        end

        // Unrecognised opcodes, including near-misses of legal ones.
        step("nop_zero", 1'b0, 7'b0000000);
        step("nop_ones", 1'b0, 7'b1111111);
        step("nop_lui", 1'b0, 7'b0110111);
        step("nop_r_lo", 1'b0, 7'b0110010);

        // Reset mid-stream while LW held.
        step("lw_pre", 1'b0, 7'b0000011);
        step("lw_rst", 1'b1, 7'b0000011);
        step("lw_post", 1'b0, 7'b0000011);

        // Back-to-back changes every cycle.
        step("b2b_r", 1'b0, 7'b0110011);
        step("b2b_sw", 1'b0, 7'b0100011);
        step("b2b_beq", 1'b0, 7'b1100011);
        step("b2b_lw", 1'b0, 7'b0000011);

        // Sweep all 128 opcodes; count how many decode to a non-zero row.
        nonzero = 0;
        for (int op = 0; op < 128; op++) begin
            step("sweep", 1'b0, 7'(op));
            if (dut_row() != 8'h00) nonzero++;
        end
        check("sweep_nonzero_count", 8'(nonzero), 8'd5);

        // Random traffic, biased towards legal opcodes, with occasional reset.
        for (int n = 0; n < 400; n++) begin
            logic [6:0] op;
            logic       rst;
            op  = ($urandom_range(0, 1) == 0) ? legal[$urandom_range(0, 4)] : 7'($urandom);
            rst = ($urandom_range(0, 15) == 0);
            step("rand", rst, op);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
